// File: rtl/cam_queue_pkg.sv
// -----------------------------------------------------------------------------
// cam_queue_pkg
// Purpose : Constants and types for the 17-bit camera load queue. The camera
//           writer and the frame buffer controller both use these, so the
//           entry format is defined once.
// Contents: QUEUE_W          queue entry width
//           CMD_BIT          entry bit that marks a command word
//           CMD_FRAME_START  start-of-frame command word
//           cam_wr_state_t   camera writer FSM states
//           pixel_entry()    builds a pixel entry from hi/lo bytes
// -----------------------------------------------------------------------------
package cam_queue_pkg;

  localparam int QUEUE_W = 17;
  localparam int CMD_BIT = 16;
  localparam logic [QUEUE_W-1:0] CMD_FRAME_START = 17'h10000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DROP    = 2'd3
  } cam_wr_state_t;

  // Pixel entries have the command flag clear and carry RGB565 as {hi, lo}.
  function automatic logic [QUEUE_W-1:0] pixel_entry(input logic [7:0] hi,
                                                     input logic [7:0] lo);
    logic [QUEUE_W-1:0] e;
    e = '0;
    e[CMD_BIT-1:0] = {hi, lo};
    return e;
  endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// -----------------------------------------------------------------------------
// cam_byte_packer
// Purpose : Pairs consecutive camera bytes into 16-bit RGB565 pixels.
//           The first byte of a pair is held in hi_q. pixel_valid_o pulses
//           combinationally on the edge that presents the second byte.
// Ports   : clk           in   pixel clock
//           rst_n         in   asynchronous active-low reset
//           clear_i       in   drop any half pixel and restart at phase 0
//           byte_valid_i  in   byte_i is a captured byte this cycle
//           byte_i        in   camera byte
//           pixel_valid_o out  a full pixel is available on pixel_o
//           pixel_o       out  {hi_byte, lo_byte}
// -----------------------------------------------------------------------------
module cam_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        pixel_valid_o,
  output logic [15:0] pixel_o
);

  logic       phase_q;
  logic [7:0] hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else if (clear_i) begin
      phase_q <= 1'b0;
    end else if (byte_valid_i) begin
      phase_q <= ~phase_q;
      if (!phase_q) hi_q <= byte_i;
    end
  end

  assign pixel_valid_o = byte_valid_i & phase_q & ~clear_i;
  assign pixel_o       = {hi_q, byte_i};

endmodule

// File: rtl/cam_queue_writer.sv
// -----------------------------------------------------------------------------
// cam_queue_writer
// Purpose : Camera-side producer for the camera load queue. Samples the
//           OV7670 parallel bus, writes a start-of-frame marker on each vsync
//           fall, then writes one {1'b0, hi, lo} entry per RGB565 pixel.
// Ports   : clk          in      camera pixel clock
//           rst_n        in      asynchronous active-low reset
//           enable       in      capture enable
//           cam_vsync    in      vsync, high = blanking/sync
//           cam_href     in      line valid, one byte per clk while high
//           cam_data     in  8   camera byte
//           queue_full   in      FIFO full flag
//           queue_data   out 17  FIFO write data, bit 16 = command flag
//           queue_wr_en  out     FIFO write strobe
//           frame_count  out 16  start markers written (wraps)
//           overflow     out     sticky: entry dropped because queue_full
//           line_error   out     sticky: line byte count != 2*FRAME_WIDTH
// -----------------------------------------------------------------------------
module cam_queue_writer
  import cam_queue_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [7:0]         cam_data,
  input  logic               queue_full,
  output logic [QUEUE_W-1:0] queue_data,
  output logic               queue_wr_en,
  output logic [15:0]        frame_count,
  output logic               overflow,
  output logic               line_error
);

  localparam logic [10:0] LINE_BYTES = 11'(2 * FRAME_WIDTH);
  localparam logic [9:0]  MAX_LINES  = 10'(FRAME_HEIGHT);

  cam_wr_state_t      state_q;
  logic               vsync_q;
  logic               href_q;
  logic [10:0]        byte_cnt_q;
  logic [9:0]         line_cnt_q;
  logic [QUEUE_W-1:0] queue_data_q;
  logic               wr_en_q;
  logic [15:0]        frame_count_q;
  logic               overflow_q;
  logic               line_error_q;

  logic        vsync_fall;
  logic        href_fall;
  logic        line_active;
  logic        capturing;
  logic        byte_valid;
  logic        packer_clear;
  logic        pixel_valid;
  logic [15:0] pixel;

  assign vsync_fall  = vsync_q & ~cam_vsync;
  assign href_fall   = href_q & ~cam_href;
  // Lines past FRAME_HEIGHT are ignored entirely: no pixels, no length check.
  assign line_active = (line_cnt_q < MAX_LINES);
  // Bytes are only taken in CAPTURE while enabled and outside vsync; any other
  // condition (including the vsync that ends the frame) drops a half pixel.
  assign capturing    = (state_q == CAPTURE) & enable & ~cam_vsync;
  assign byte_valid   = capturing & cam_href & line_active;
  assign packer_clear = ~capturing | href_fall;

  cam_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (packer_clear),
    .byte_valid_i (byte_valid),
    .byte_i       (cam_data),
    .pixel_valid_o(pixel_valid),
    .pixel_o      (pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      byte_cnt_q    <= '0;
      line_cnt_q    <= '0;
      queue_data_q  <= '0;
      wr_en_q       <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      line_error_q  <= 1'b0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
      wr_en_q <= 1'b0;

      if (!enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= WAIT_VS;

          WAIT_VS: begin
            if (vsync_fall) begin
              if (!queue_full) begin
                queue_data_q  <= CMD_FRAME_START;
                wr_en_q       <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
                byte_cnt_q    <= '0;
                line_cnt_q    <= '0;
                state_q       <= CAPTURE;
              end else begin
                overflow_q <= 1'b1;
                state_q    <= DROP;
              end
            end
          end

          CAPTURE: begin
            if (cam_vsync) begin
              state_q <= WAIT_VS;
            end else begin
              if (byte_valid && byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 11'd1;
              if (href_fall) begin
                if (line_active && byte_cnt_q != LINE_BYTES) line_error_q <= 1'b1;
                byte_cnt_q <= '0;
                if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + 10'd1;
              end
              if (pixel_valid) begin
                if (queue_full) begin
                  // Once a pixel is lost the rest of the frame is useless;
                  // the consumer resyncs on the next start marker.
                  overflow_q <= 1'b1;
                  state_q    <= DROP;
                end else begin
                  queue_data_q <= pixel_entry(pixel[15:8], pixel[7:0]);
                  wr_en_q      <= 1'b1;
                end
              end
            end
          end

          DROP: if (cam_vsync) state_q <= WAIT_VS;

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign queue_data  = queue_data_q;
  assign queue_wr_en = wr_en_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
  assign line_error  = line_error_q;

endmodule
